// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder: valid/ready request in, one-cycle response pulse out.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      counter;
  logic            write_reg;
  logic [AW+1:0]   addr_reg;
  logic [31:0]     wdata_reg;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            do_access;
  logic            acc_write;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic [AW-1:0]   idx;
  logic            misaligned;
  logic            unused_bits;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;

  // With zero wait states the access happens on the accept edge, using the live request.
  always_comb begin
    acc_write = write_reg;
    acc_addr  = addr_reg;
    acc_wdata = wdata_reg;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr[AW+1:0];
      acc_wdata = req_wdata;
    end
  end

  assign do_access = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (counter == 4'd0));
  assign idx       = acc_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (acc_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Upper address bits alias; byte-offset bits only matter with the alignment check.
  assign unused_bits = ^{req_addr[31:AW+2], acc_addr[1:0]};

  always_ff @(posedge clock) begin
    if (do_access && acc_write && !misaligned) begin
      mem[idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      counter   <= 4'd0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= do_access;
      if (do_access) begin
        rsp_rdata <= (acc_write || misaligned) ? 32'd0 : mem[idx];
        rsp_err   <= misaligned;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            write_reg <= req_write;
            addr_reg  <= req_addr[AW+1:0];
            wdata_reg <= req_wdata;
            counter   <= CNT_INIT;
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (counter == 4'd0) state <= RESP;
          else                 counter <= counter - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
